// File: rtl/fft_pkg.sv
// +--------------------------------------------------------------------+
// | fft_pkg : register map, APB states and reset defaults for FFT regs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fft_pkg;

   localparam logic [7:0] FFT_CTRL_ADDR         = 8'h00;
   localparam logic [7:0] FFT_STATUS_ADDR       = 8'h04;
   localparam logic [7:0] FFT_CONFIG_ADDR       = 8'h08;
   localparam logic [7:0] FFT_LENGTH_ADDR       = 8'h0C;
   localparam logic [7:0] FFT_INT_ENABLE_ADDR   = 8'h14;
   localparam logic [7:0] FFT_INT_STATUS_ADDR   = 8'h18;
   localparam logic [7:0] FFT_SCALE_ADDR        = 8'h1C;
   localparam logic [7:0] FFT_RESCALE_CTRL_ADDR = 8'h20;
   localparam logic [7:0] OVF_STATUS_ADDR       = 8'h24;

   localparam int INT_DONE_BIT  = 0;
   localparam int INT_ERROR_BIT = 1;
   localparam int INT_RSVD_BIT  = 2;
   localparam int INT_OVF_BIT   = 3;

   localparam logic [3:0]  DEFAULT_LOG2   = 4'd10;
   localparam logic [12:0] DEFAULT_LENGTH = 13'd1024;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic [31:0] ctrl;
      logic [31:0] status;
      logic [31:0] cfg;
      logic [31:0] length;
      logic [31:0] int_en;
      logic [31:0] int_status;
      logic [31:0] scale;
      logic [31:0] rescale;
      logic [31:0] ovf;
   } fft_regs_t;

endpackage

`default_nettype wire

// File: rtl/fft_apb_if.sv
// +--------------------------------------------------------------------+
// | fft_apb_if : APB responder FSM, write strobe and registered rdata   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fft_apb_if
   import fft_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 16
) (
   input  logic                      pclk_i,
   input  logic                      preset_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  fft_regs_t                 rd_regs_i,
   output logic [31:0]               prdata_o,
   output logic                      pready_o,
   output logic                      wr_en_o,
   output logic [5:0]                addr_o
);

   apb_state_e  state_q, state_d;
   logic [31:0] prdata_q, prdata_d;
   logic [31:0] rd_mux;
   logic        first_access;
   logic        unused_paddr;

   assign addr_o       = paddr_i[7:2];
   assign unused_paddr = ^paddr_i;
   // SETUP state plus penable marks the first ACCESS cycle on the bus
   assign first_access = (state_q == APB_SETUP) && psel_i && penable_i;

   always_comb begin
      rd_mux = 32'd0;
      case (addr_o)
         FFT_CTRL_ADDR[7:2]:         rd_mux = rd_regs_i.ctrl;
         FFT_STATUS_ADDR[7:2]:       rd_mux = rd_regs_i.status;
         FFT_CONFIG_ADDR[7:2]:       rd_mux = rd_regs_i.cfg;
         FFT_LENGTH_ADDR[7:2]:       rd_mux = rd_regs_i.length;
         FFT_INT_ENABLE_ADDR[7:2]:   rd_mux = rd_regs_i.int_en;
         FFT_INT_STATUS_ADDR[7:2]:   rd_mux = rd_regs_i.int_status;
         FFT_SCALE_ADDR[7:2]:        rd_mux = rd_regs_i.scale;
         FFT_RESCALE_CTRL_ADDR[7:2]: rd_mux = rd_regs_i.rescale;
         OVF_STATUS_ADDR[7:2]:       rd_mux = rd_regs_i.ovf;
         default:                    rd_mux = 32'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      prdata_d = prdata_q;
      case (state_q)
         APB_IDLE: begin
            if (psel_i && !penable_i) state_d = APB_SETUP;
         end
         APB_SETUP: begin
            if (first_access && !pwrite_i) begin
               state_d  = APB_ACCESS;
               prdata_d = rd_mux;
            end else begin
               state_d = APB_IDLE;
            end
         end
         APB_ACCESS: state_d = APB_IDLE;
         default:    state_d = APB_IDLE;
      endcase
   end

   assign wr_en_o  = first_access && pwrite_i;
   assign pready_o = wr_en_o || (state_q == APB_ACCESS);
   assign prdata_o = (state_q == APB_ACCESS) ? prdata_q : 32'd0;

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state_q  <= APB_IDLE;
         prdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         prdata_q <= prdata_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fft_apb_regs.sv
// +--------------------------------------------------------------------+
// | fft_apb_regs : FFT control/status register bank and event capture  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fft_apb_regs
   import fft_pkg::*;
#(
   parameter int FFT_MAX_LENGTH_LOG2 = 12,
   parameter int APB_ADDR_WIDTH      = 16
) (
   input  logic                      pclk_i,
   input  logic                      preset_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic [31:0]               pwdata_i,
   output logic [31:0]               prdata_o,
   output logic                      pready_o,
   output logic                      start_o,
   output logic [3:0]                log2_len_o,
   output logic                      rescale_en_o,
   output logic                      scale_track_o,
   output logic                      ovf_det_en_o,
   output logic [3:0]                rescale_ctrl_o,
   input  logic                      busy_i,
   input  logic                      done_i,
   input  logic                      error_i,
   input  logic                      overflow_i,
   input  logic [7:0]                scale_factor_i,
   output logic                      fft_done_o,
   output logic                      fft_error_o
);

   localparam logic [3:0] MAX_LOG2 = 4'(FFT_MAX_LENGTH_LOG2);
   localparam logic [3:0] MIN_LOG2 = 4'd3;

   logic        wr_en;
   logic [5:0]  addr;
   fft_regs_t   rd_regs;
   logic        unused_pwdata;

   logic [1:0]  ctrl_q, ctrl_d;
   logic        done_q, done_d, err_q, err_d;
   logic [3:0]  log2_q, log2_d;
   logic        ovf_en_q, ovf_en_d;
   logic [12:0] length_q, length_d;
   logic [3:0]  int_en_q, int_en_d, int_stat_q, int_stat_d, rescale_q, rescale_d;
   logic [7:0]  scale_q, scale_d, ovf_cnt_q, ovf_cnt_d;
   logic        start_q, start_d, fft_done_q, fft_done_d, fft_error_q, fft_error_d;

   logic        len_ok, start_req, start_ok, start_bad, ovf_event;

   fft_apb_if #(.APB_ADDR_WIDTH(APB_ADDR_WIDTH)) u_apb_if (
      .pclk_i    (pclk_i),
      .preset_i  (preset_i),
      .psel_i    (psel_i),
      .penable_i (penable_i),
      .pwrite_i  (pwrite_i),
      .paddr_i   (paddr_i),
      .rd_regs_i (rd_regs),
      .prdata_o  (prdata_o),
      .pready_o  (pready_o),
      .wr_en_o   (wr_en),
      .addr_o    (addr)
   );

   assign unused_pwdata = ^pwdata_i;
   assign len_ok    = (length_q == (13'd1 << log2_q));
   assign start_req = wr_en && (addr == FFT_CTRL_ADDR[7:2]) && pwdata_i[0] && !busy_i;
   assign start_ok  = start_req && len_ok;
   assign start_bad = start_req && !len_ok;
   assign ovf_event = overflow_i && ovf_en_q;

   always_comb begin
      ctrl_d      = ctrl_q;
      done_d      = done_q;
      err_d       = err_q;
      log2_d      = log2_q;
      ovf_en_d    = ovf_en_q;
      length_d    = length_q;
      int_en_d    = int_en_q;
      int_stat_d  = int_stat_q;
      rescale_d   = rescale_q;
      scale_d     = scale_q;
      ovf_cnt_d   = ovf_cnt_q;
      start_d     = start_ok;
      fft_done_d  = int_stat_q[INT_DONE_BIT] && int_en_q[INT_DONE_BIT];
      fft_error_d = |(int_stat_q[3:1] & int_en_q[3:1]);

      if (wr_en) begin
         case (addr)
            FFT_CTRL_ADDR[7:2]:         ctrl_d    = pwdata_i[5:4];
            FFT_CONFIG_ADDR[7:2]: begin
               ovf_en_d = pwdata_i[19];
               if (pwdata_i[3:0] >= MIN_LOG2 && pwdata_i[3:0] <= MAX_LOG2)
                  log2_d = pwdata_i[3:0];
            end
            FFT_LENGTH_ADDR[7:2]:       length_d  = pwdata_i[12:0];
            FFT_INT_ENABLE_ADDR[7:2]:   int_en_d  = pwdata_i[3:0];
            FFT_INT_STATUS_ADDR[7:2]:   int_stat_d = int_stat_q & ~pwdata_i[3:0];
            FFT_RESCALE_CTRL_ADDR[7:2]: rescale_d = pwdata_i[3:0];
            default: ;
         endcase
      end

      // Clears are applied before sets so a coincident event always wins
      if (start_ok) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      if (done_i) begin
         done_d                   = 1'b1;
         int_stat_d[INT_DONE_BIT] = 1'b1;
         scale_d                  = scale_factor_i;
      end
      if (error_i || start_bad) begin
         err_d                     = 1'b1;
         int_stat_d[INT_ERROR_BIT] = 1'b1;
      end
      if (ovf_event) int_stat_d[INT_OVF_BIT] = 1'b1;
      int_stat_d[INT_RSVD_BIT] = 1'b0;

      if ((wr_en && addr == OVF_STATUS_ADDR[7:2]) || start_ok)
         ovf_cnt_d = 8'd0;
      else if (ovf_event && ovf_cnt_q != 8'hFF)
         ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         ctrl_q      <= 2'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         log2_q      <= DEFAULT_LOG2;
         ovf_en_q    <= 1'b0;
         length_q    <= DEFAULT_LENGTH;
         int_en_q    <= 4'd0;
         int_stat_q  <= 4'd0;
         rescale_q   <= 4'd0;
         scale_q     <= 8'd0;
         ovf_cnt_q   <= 8'd0;
         start_q     <= 1'b0;
         fft_done_q  <= 1'b0;
         fft_error_q <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         done_q      <= done_d;
         err_q       <= err_d;
         log2_q      <= log2_d;
         ovf_en_q    <= ovf_en_d;
         length_q    <= length_d;
         int_en_q    <= int_en_d;
         int_stat_q  <= int_stat_d;
         rescale_q   <= rescale_d;
         scale_q     <= scale_d;
         ovf_cnt_q   <= ovf_cnt_d;
         start_q     <= start_d;
         fft_done_q  <= fft_done_d;
         fft_error_q <= fft_error_d;
      end
   end

   assign rd_regs.ctrl       = {26'd0, ctrl_q, 4'd0};
   assign rd_regs.status     = {29'd0, err_q, done_q, busy_i};
   assign rd_regs.cfg        = {12'd0, ovf_en_q, 15'd0, log2_q};
   assign rd_regs.length     = {19'd0, length_q};
   assign rd_regs.int_en     = {28'd0, int_en_q};
   assign rd_regs.int_status = {28'd0, int_stat_q};
   assign rd_regs.scale      = {24'd0, scale_q};
   assign rd_regs.rescale    = {28'd0, rescale_q};
   assign rd_regs.ovf        = {24'd0, ovf_cnt_q};

   assign start_o        = start_q;
   assign log2_len_o     = log2_q;
   assign rescale_en_o   = ctrl_q[0];
   assign scale_track_o  = ctrl_q[1];
   assign ovf_det_en_o   = ovf_en_q;
   assign rescale_ctrl_o = rescale_q;
   assign fft_done_o     = fft_done_q;
   assign fft_error_o    = fft_error_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_apb_regs.sv
// +--------------------------------------------------------------------+
// | tb_fft_apb_regs : self-checking bench for fft_apb_regs             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fft_apb_regs;

   logic        pclk_i = 1'b0;
   logic        preset_i, psel_i, penable_i, pwrite_i;
   logic [15:0] paddr_i;
   logic [31:0] pwdata_i, prdata_o;
   logic        pready_o, start_o, rescale_en_o, scale_track_o, ovf_det_en_o;
   logic [3:0]  log2_len_o, rescale_ctrl_o;
   logic        busy_i, done_i, error_i, overflow_i;
   logic [7:0]  scale_factor_i;
   logic        fft_done_o, fft_error_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          start_cnt = 0;
   logic [31:0] exp_q[$];

   fft_apb_regs #(.FFT_MAX_LENGTH_LOG2(12), .APB_ADDR_WIDTH(16)) dut (
      .pclk_i(pclk_i), .preset_i(preset_i), .psel_i(psel_i), .penable_i(penable_i),
      .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
      .pready_o(pready_o), .start_o(start_o), .log2_len_o(log2_len_o),
      .rescale_en_o(rescale_en_o), .scale_track_o(scale_track_o),
      .ovf_det_en_o(ovf_det_en_o), .rescale_ctrl_o(rescale_ctrl_o), .busy_i(busy_i),
      .done_i(done_i), .error_i(error_i), .overflow_i(overflow_i),
      .scale_factor_i(scale_factor_i), .fft_done_o(fft_done_o), .fft_error_o(fft_error_o)
   );

   always #5 pclk_i = ~pclk_i;

   always @(negedge pclk_i) if (start_o === 1'b1) start_cnt++;

   // acc = extra ACCESS cycles before pready_o (0 = first ACCESS cycle), 99 on timeout
   task automatic apb_xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int acc);
      @(negedge pclk_i);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = wd;
      @(negedge pclk_i);
      penable_i = 1'b1;
      acc = 0;
      #1;
      while (pready_o !== 1'b1 && acc < 8) begin
         @(negedge pclk_i); #1; acc++;
      end
      if (pready_o !== 1'b1) acc = 99;
      rd = prdata_o;
      @(negedge pclk_i);
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   task automatic apb_write(input logic [15:0] a, input logic [31:0] wd);
      logic [31:0] rd;
      int acc;
      apb_xfer(1'b1, a, wd, rd, acc);
      n_tests++;
      if (acc !== 0) begin
         n_fail++; $display("FAIL write_latency @%h: got %0d extra cycles, expected 0", a, acc);
      end
   endtask

   task automatic test_reset();
      logic [15:0] addrs [9] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h14,
                                 16'h18, 16'h1C, 16'h20, 16'h24};
      logic [31:0] vals  [9] = '{32'h0, 32'h0, 32'h0000000A, 32'h400, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0};
      logic [31:0] d, e;
      int acc;
      preset_i = 1'b1;
      repeat (3) @(negedge pclk_i);
      preset_i = 1'b0;
      #1;
      n_tests++;
      if ({start_o, rescale_en_o, scale_track_o, ovf_det_en_o, rescale_ctrl_o,
           fft_done_o, fft_error_o, pready_o, prdata_o} !== 42'd0) begin
         n_fail++; $display("FAIL reset_outputs: got nonzero, expected all zero");
      end
      n_tests++;
      if (log2_len_o !== 4'd10) begin
         n_fail++; $display("FAIL reset_log2: got %0d expected 10", log2_len_o);
      end
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(vals[i]);
         apb_xfer(1'b0, addrs[i], 32'h0, d, acc);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++; $display("FAIL reset_read @%h: got %h expected %h", addrs[i], d, e);
         end
         n_tests++;
         if (acc !== 1) begin
            n_fail++; $display("FAIL read_latency @%h: got %0d extra cycles, expected 1", addrs[i], acc);
         end
      end
   endtask

   task automatic test_start();
      logic [31:0] d, e;
      int acc, s0;
      apb_write(16'h08, 32'h0008000A);
      n_tests++;
      if (ovf_det_en_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_det_en: got %b expected 1", ovf_det_en_o);
      end
      s0 = start_cnt;
      apb_write(16'h00, 32'h31);
      n_tests++;
      if (start_o !== 1'b1) begin
         n_fail++; $display("FAIL start_timing: got %b expected 1", start_o);
      end
      repeat (3) @(negedge pclk_i);
      n_tests++;
      if (start_cnt - s0 !== 1) begin
         n_fail++; $display("FAIL start_pulses: got %0d expected 1", start_cnt - s0);
      end
      n_tests++;
      if ({rescale_en_o, scale_track_o} !== 2'b11) begin
         n_fail++; $display("FAIL ctrl_ports: got %b expected 11", {rescale_en_o, scale_track_o});
      end
      exp_q.push_back(32'h30);
      apb_xfer(1'b0, 16'h00, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL ctrl_read: got %h expected %h", d, e);
      end
   endtask

   task automatic test_done();
      logic [15:0] addrs [3] = '{16'h04, 16'h1C, 16'h18};
      logic [31:0] d, e;
      int acc, s0;
      s0 = start_cnt;
      // START write collides with done_i while busy_i is still high
      @(negedge pclk_i);
      busy_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
      paddr_i = 16'h00; pwdata_i = 32'h1;
      @(negedge pclk_i);
      penable_i = 1'b1; done_i = 1'b1; scale_factor_i = 8'h05;
      #1;
      n_tests++;
      if (pready_o !== 1'b1) begin
         n_fail++; $display("FAIL done_collide_pready: got %b expected 1", pready_o);
      end
      @(negedge pclk_i);
      psel_i = 1'b0; penable_i = 1'b0; done_i = 1'b0; busy_i = 1'b0; scale_factor_i = 8'h00;
      repeat (2) @(negedge pclk_i);
      n_tests++;
      if (start_cnt !== s0) begin
         n_fail++; $display("FAIL done_collide_start: got %0d pulses expected 0", start_cnt - s0);
      end
      exp_q.push_back(32'h2); exp_q.push_back(32'h05); exp_q.push_back(32'h1);
      for (int i = 0; i < 3; i++) begin
         apb_xfer(1'b0, addrs[i], 32'h0, d, acc);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++; $display("FAIL done_read @%h: got %h expected %h", addrs[i], d, e);
         end
      end
      apb_write(16'h14, 32'h1);
      repeat (2) @(negedge pclk_i);
      #1;
      n_tests++;
      if (fft_done_o !== 1'b1) begin
         n_fail++; $display("FAIL fft_done_set: got %b expected 1", fft_done_o);
      end
      apb_write(16'h18, 32'h1);
      repeat (2) @(negedge pclk_i);
      #1;
      n_tests++;
      if (fft_done_o !== 1'b0) begin
         n_fail++; $display("FAIL fft_done_clear: got %b expected 0", fft_done_o);
      end
   endtask

   task automatic test_mismatch();
      logic [31:0] d, e;
      int acc, s0;
      apb_write(16'h0C, 32'h100);
      s0 = start_cnt;
      apb_write(16'h00, 32'h1);
      repeat (3) @(negedge pclk_i);
      n_tests++;
      if (start_cnt !== s0) begin
         n_fail++; $display("FAIL mismatch_start: got %0d pulses expected 0", start_cnt - s0);
      end
      exp_q.push_back(32'h6);
      apb_xfer(1'b0, 16'h04, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL mismatch_status: got %h expected %h", d, e);
      end
      exp_q.push_back(32'h2);
      apb_xfer(1'b0, 16'h18, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL mismatch_int_status: got %h expected %h", d, e);
      end
      apb_write(16'h14, 32'h2);
      repeat (2) @(negedge pclk_i);
      #1;
      n_tests++;
      if ({fft_error_o, fft_done_o} !== 2'b10) begin
         n_fail++; $display("FAIL fft_error_irq: got %b expected 10", {fft_error_o, fft_done_o});
      end
      // Matching length but engine busy: still ignored
      apb_write(16'h0C, 32'h400);
      busy_i = 1'b1;
      apb_write(16'h00, 32'h1);
      busy_i = 1'b0;
      repeat (2) @(negedge pclk_i);
      n_tests++;
      if (start_cnt !== s0) begin
         n_fail++; $display("FAIL busy_start: got %0d pulses expected 0", start_cnt - s0);
      end
      apb_write(16'h00, 32'h1);
      repeat (2) @(negedge pclk_i);
      n_tests++;
      if (start_cnt - s0 !== 1) begin
         n_fail++; $display("FAIL accepted_start: got %0d pulses expected 1", start_cnt - s0);
      end
      exp_q.push_back(32'h0);
      apb_xfer(1'b0, 16'h04, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL status_cleared: got %h expected %h", d, e);
      end
      apb_write(16'h18, 32'h2);
      repeat (2) @(negedge pclk_i);
      #1;
      n_tests++;
      if (fft_error_o !== 1'b0) begin
         n_fail++; $display("FAIL fft_error_clear: got %b expected 0", fft_error_o);
      end
   endtask

   task automatic test_config();
      logic [31:0] wv [3] = '{32'h00000002, 32'h0008000C, 32'h0008000D};
      logic [31:0] ev [3] = '{32'h0000000A, 32'h0008000C, 32'h0008000C};
      logic [31:0] d, e;
      int acc;
      for (int i = 0; i < 3; i++) begin
         apb_write(16'h08, wv[i]);
         exp_q.push_back(ev[i]);
         apb_xfer(1'b0, 16'h08, 32'h0, d, acc);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e || log2_len_o !== e[3:0] || ovf_det_en_o !== e[19]) begin
            n_fail++; $display("FAIL config_write %h: got %h log2=%0d expected %h", wv[i], d, log2_len_o, e);
         end
      end
      apb_write(16'h08, 32'h0008000A);
   endtask

   task automatic test_overflow();
      logic [31:0] d, e;
      int acc;
      apb_write(16'h24, 32'h0);
      @(negedge pclk_i); overflow_i = 1'b1;
      repeat (300) @(negedge pclk_i);
      overflow_i = 1'b0;
      exp_q.push_back(32'hFF); exp_q.push_back(32'h8);
      apb_xfer(1'b0, 16'h24, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL ovf_saturate: got %h expected %h", d, e);
      end
      apb_xfer(1'b0, 16'h18, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL ovf_int_status: got %h expected %h", d, e);
      end
      apb_write(16'h24, 32'h1234);
      apb_write(16'h08, 32'h0000000A);
      @(negedge pclk_i); overflow_i = 1'b1;
      repeat (5) @(negedge pclk_i);
      overflow_i = 1'b0;
      exp_q.push_back(32'h0);
      apb_xfer(1'b0, 16'h24, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL ovf_clear_and_disable: got %h expected %h", d, e);
      end
      apb_write(16'h18, 32'h8);
      exp_q.push_back(32'h0);
      apb_xfer(1'b0, 16'h18, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
         n_fail++; $display("FAIL ovf_w1c: got %h expected %h", d, e);
      end
   endtask

   task automatic test_misc();
      logic [15:0] addrs [4] = '{16'h20, 16'h10, 16'h28, 16'h0A};
      logic [31:0] d, e;
      int acc;
      apb_write(16'h20, 32'hF5);
      apb_write(16'h10, 32'hFFFFFFFF);
      n_tests++;
      if (rescale_ctrl_o !== 4'h5) begin
         n_fail++; $display("FAIL rescale_port: got %h expected 5", rescale_ctrl_o);
      end
      exp_q.push_back(32'h5); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0); exp_q.push_back(32'hA);
      for (int i = 0; i < 4; i++) begin
         apb_xfer(1'b0, addrs[i], 32'h0, d, acc);
         e = exp_q.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++; $display("FAIL misc_read @%h: got %h expected %h", addrs[i], d, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, e;
      int acc;
      @(negedge pclk_i);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 16'h08;
      @(negedge pclk_i);
      penable_i = 1'b1;
      #1;
      n_tests++;
      if (pready_o !== 1'b0) begin
         n_fail++; $display("FAIL mid_wait_state: got pready %b expected 0", pready_o);
      end
      preset_i = 1'b1;
      @(negedge pclk_i);
      #1;
      n_tests++;
      if (pready_o !== 1'b0 || prdata_o !== 32'd0) begin
         n_fail++; $display("FAIL mid_reset_drop: got pready %b data %h expected 0", pready_o, prdata_o);
      end
      @(negedge pclk_i);
      preset_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
      exp_q.push_back(32'h0000000A);
      apb_xfer(1'b0, 16'h08, 32'h0, d, acc);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e || acc !== 1) begin
         n_fail++; $display("FAIL post_reset_read: got %h after %0d extra expected %h after 1", d, acc, e);
      end
   endtask

   initial begin
      preset_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
      paddr_i = 16'h0; pwdata_i = 32'h0; busy_i = 1'b0; done_i = 1'b0;
      error_i = 1'b0; overflow_i = 1'b0; scale_factor_i = 8'h0;
      test_reset();
      test_start();
      test_done();
      test_mismatch();
      test_config();
      test_overflow();
      test_misc();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
